// File: rtl/id_stage.sv
// Instruction decode stage: RV32I decode, immediate generation, WB bypass,
// load-use interlock and the ID/EX pipeline register.
module id_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        uses_rs1;
        logic        uses_rs2;
    } dec_t;

    dec_t        dec;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] op1, op2;
    logic        load_use;
    logic        accept;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];

    // Opcode decode: immediate format, control bits and source usage
    always_comb begin
        dec = '0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
            end
            OP_IALU, OP_LOAD, OP_JALR: begin
                dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
                dec.reg_write = 1'b1;
                dec.mem_read  = (opcode == OP_LOAD);
                dec.uses_rs1  = 1'b1;
            end
            OP_STORE: begin
                dec.imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                dec.mem_write = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm      = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                if_instr[30:25], if_instr[11:8], 1'b0};
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.imm       = {if_instr[31:12], 12'b0};
                dec.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec.imm       = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                 if_instr[20], if_instr[30:21], 1'b0};
                dec.reg_write = 1'b1;
            end
            default: dec = '0;
        endcase
        // Writes to x0 are architecturally dropped, so never flag them
        if (rd == 5'd0) dec.reg_write = 1'b0;
    end

    // Operand select: x0 is hardwired zero, otherwise forward a same-cycle WB write
    always_comb begin
        op1 = rf_rs1_data;
        op2 = rf_rs2_data;
        if (rf_rs1 == 5'd0)                   op1 = '0;
        else if (wb_we && wb_rd == rf_rs1)    op1 = wb_data;
        if (rf_rs2 == 5'd0)                   op2 = '0;
        else if (wb_we && wb_rd == rf_rs2)    op2 = wb_data;
    end

    // Load-use interlock and ready; ready is held low throughout reset
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((dec.uses_rs1 && ex_rd == rf_rs1) || (dec.uses_rs2 && ex_rd == rf_rs2));
        id_ready = reset_n && !flush && !load_use && (!ex_valid || ex_ready);
        accept   = if_valid && id_ready;
    end

    // ID/EX register: reset > flush > accept > drain > hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_rs1_data  <= op1;
            ex_rs2_data  <= op2;
            ex_imm       <= dec.imm;
            ex_rd        <= rd;
            ex_opcode    <= opcode;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_reg_write <= dec.reg_write;
            ex_mem_read  <= dec.mem_read;
            ex_mem_write <= dec.mem_write;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on posedge clk only.
REQ-002 clk  in  1  pipeline clock.
REQ-003 reset_n  in  1  synchronous active-low reset, sampled at posedge clk.
REQ-004 if_valid  in  1  IF/ID holds a valid instruction; if_instr  in  32  instruction word; if_pc  in  32  its PC.
REQ-005 id_ready  out  1  combinational; instruction accepted at posedge when if_valid && id_ready.
REQ-006 rf_rs1, rf_rs2  out  5  combinational register-file read addresses (if_instr[19:15], [24:20]).
REQ-007 rf_rs1_data, rf_rs2_data  in  32  combinational register-file read data.
REQ-008 wb_we  in  1; wb_rd  in  5; wb_data  in  32  write-back port, same signals driven to the register file.
REQ-009 ex_ready  in  1  EX consumes ID/EX contents at posedge when ex_valid && ex_ready; flush  in  1  discard.
REQ-010 ex_valid  out  1; ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32; ex_rd  out  5; ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1; ex_reg_write, ex_mem_read, ex_mem_write  out  1 -- all registered.

Function
REQ-011 SHALL decode opcodes R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-012 ex_imm SHALL be sign-extended I/S/B/U/J immediate per format (B, J bit0 = 0; U low 12 bits = 0); R and unknown -> 0.
REQ-013 reg_write = 1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR and rd != 0; mem_read = LOAD; mem_write = STORE; unknown opcode -> all three 0, ex_valid still follows handshake.
REQ-014 uses_rs1 for R, I-ALU, LOAD, STORE, BRANCH, JALR; uses_rs2 for R, STORE, BRANCH; unused sources never cause a stall.
REQ-015 Bypass: operand = wb_data when wb_we && wb_rd == rs && rs != 0, else rf data; rs == 0 SHALL yield 0 regardless of inputs.
REQ-016 load_use = ex_valid && ex_mem_read && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)).
REQ-017 id_ready = !flush && !load_use && (!ex_valid || ex_ready).
REQ-018 Priority per posedge: reset, then flush (ex_valid <= 0), then accept (load all ex_* from decode, ex_valid <= 1), then drain (ex_valid && ex_ready -> ex_valid <= 0, bubble), else hold all ex_* unchanged.
REQ-019 Load-use SHALL insert exactly one bubble: stalled instruction accepted the cycle after the load leaves ID/EX.
REQ-020 Latency: one cycle from accept to ex_valid; throughput one instruction/cycle without hazards.
REQ-021 While !ex_ready && ex_valid, ex_* SHALL be stable; bypass is sampled only at accept.
REQ-022 Flush concurrent with if_valid SHALL accept nothing; flush while stalled clears ex_valid and the stall.

Reset
REQ-023 reset_n low at posedge SHALL clear every ex_* output to 0 including ex_valid; id_ready = 0 while reset_n low.
REQ-024 Reset mid-stall or mid-hold SHALL discard the held instruction; first accept possible on the first posedge after reset_n high.

Verification
REQ-025 addi x5,x0,7 (0x00700293) pc 0x100, ex_ready=1 -> next cycle ex_valid=1, ex_rd=5, ex_imm=7, ex_reg_write=1, ex_pc=0x100.
REQ-026 lw x6,0(x1) accepted, then add x7,x6,x2 presented -> id_ready=0 one cycle, ex_valid=0 bubble, add accepted next cycle.
REQ-027 wb_we=1, wb_rd=3, wb_data=0xDEAD, rf_rs1_data=0 at accept of rs1=x3 -> ex_rs1_data=0xDEAD; same with wb_rd=0, rs1=x0 -> 0.
REQ-028 ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0, ex_* unchanged; ex_ready=1 -> next instruction loaded.
REQ-029 flush=1 with if_valid=1 and ex_valid=1 -> next cycle ex_valid=0, instruction not accepted; reset_n=0 mid-hold -> all ex_* = 0.
REQ-030 beq imm -8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0.
